// File: rtl/keypad_pkg.sv
// Shared keypad constants, key bitmap type and lowest-set-key encoder.
package keypad_pkg;

  localparam int unsigned KEY_ROWS = 4;
  localparam int unsigned KEY_COLS = 4;
  localparam int unsigned NUM_KEYS = 16;

  localparam int unsigned KEY_DEC  = 1;
  localparam int unsigned KEY_FIRE = 5;
  localparam int unsigned KEY_INC  = 9;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  function automatic logic [3:0] key_lowest(input key_vec_t keys);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a snapshot commits after DEBOUNCE_SCANS identical frames;
// press_o is the rising edge of the debounced state, one clock after commit.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  key_vec_t raw_i,
  input  logic     frame_end_i,
  output key_vec_t deb_o,
  output key_vec_t press_o
);

  localparam logic [3:0] StableMax = 4'(DEBOUNCE_SCANS - 1);

  key_vec_t   prev_q, deb_q, deb_old_q;
  logic [3:0] stable_q, stable_d;

  always_comb begin
    stable_d = '0;
    if (raw_i == prev_q) begin
      stable_d = (stable_q == StableMax) ? stable_q : stable_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q    <= '0;
      deb_q     <= '0;
      deb_old_q <= '0;
      stable_q  <= '0;
    end else begin
      deb_old_q <= deb_q;
      if (frame_end_i) begin
        stable_q <= stable_d;
        prev_q   <= raw_i;
        if (stable_d == StableMax) deb_q <= raw_i;
      end
    end
  end

  assign deb_o   = deb_q;
  assign press_o = deb_q & ~deb_old_q;

endmodule

// File: rtl/keypad_ctrl.sv
// 4x4 keypad scanner/debouncer driving player position and fire.
// Define KEYPAD_POS_WRAP_EN to make playerPos wrap instead of saturating.
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned POS_MAX        = 7,
  parameter int unsigned POS_INIT       = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] keypadRow,
  input  logic [3:0] keypadCol,
  output logic [2:0] playerPos,
  output logic       fire,
  output logic       fire_evt,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned      DwellW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [2:0]       PosMax    = 3'(POS_MAX);
  localparam logic [2:0]       PosInit   = 3'(POS_INIT);

  logic [1:0]        row_q, row_d;
  logic [DwellW-1:0] dwell_q;
  logic [3:0]        row_drv_q;
  key_vec_t          raw_q, raw_d, deb, press;
  logic              sample, frame_end, dec, inc;
  logic [2:0]        pos_q, pos_d;
  logic              fire_q, fire_evt_q, key_valid_q;
  logic [3:0]        key_code_q;
  logic              unused_press;

  assign sample    = (dwell_q == DwellLast);
  assign frame_end = sample && (row_q == 2'd3);
  assign row_d     = row_q + 2'd1;

  // raw_d already holds the row-3 sample so the debouncer sees a complete frame.
  always_comb begin
    raw_d = raw_q;
    if (sample) begin
      for (int c = 0; c < KEY_COLS; c++) begin
        raw_d[KEY_COLS * int'(row_q) + c] = ~keypadCol[c];
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_i      (clk),
    .rst_i      (rst),
    .raw_i      (raw_d),
    .frame_end_i(frame_end),
    .deb_o      (deb),
    .press_o    (press)
  );

  assign dec          = press[KEY_DEC];
  assign inc          = press[KEY_INC];
  assign unused_press = ^press;

  always_comb begin
    pos_d = pos_q;
    if (dec && !inc) begin
      if (pos_q == 3'd0) begin
`ifdef KEYPAD_POS_WRAP_EN
        pos_d = PosMax;
`else
        pos_d = 3'd0;
`endif
      end else begin
        pos_d = pos_q - 3'd1;
      end
    end else if (inc && !dec) begin
      if (pos_q >= PosMax) begin
`ifdef KEYPAD_POS_WRAP_EN
        pos_d = 3'd0;
`else
        pos_d = PosMax;
`endif
      end else begin
        pos_d = pos_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= 2'd0;
      dwell_q     <= '0;
      row_drv_q   <= 4'b1110;
      raw_q       <= '0;
      pos_q       <= PosInit;
      fire_q      <= 1'b0;
      fire_evt_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      raw_q <= raw_d;
      if (sample) begin
        dwell_q   <= '0;
        row_q     <= row_d;
        row_drv_q <= ~(4'b0001 << row_d);
      end else begin
        dwell_q <= dwell_q + DwellW'(1);
      end
      pos_q       <= pos_d;
      fire_q      <= deb[KEY_FIRE];
      fire_evt_q  <= press[KEY_FIRE];
      key_valid_q <= |deb;
      key_code_q  <= key_lowest(deb);
    end
  end

  assign keypadRow = row_drv_q;
  assign playerPos = pos_q;
  assign fire      = fire_q;
  assign fire_evt  = fire_evt_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule
